// File: rtl/fir_mc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fir_mc_pkg
// Brief    : Shared widths, type helpers and per-channel state reset values
//            for the multi-channel averaging FIR.
// Revision : 1.0 - initial release
// ============================================================================
package fir_mc_pkg;

  localparam int MAX_W    = 32;
  localparam int MAX_TAPS = 16;

  typedef logic signed [MAX_W-1:0]                   sample_t;
  typedef logic signed [MAX_W+$clog2(MAX_TAPS)-1:0]  sum_t;

  localparam int C_WP_RST   = 0;
  localparam int C_FILL_RST = 0;
  localparam int C_SUM_RST  = 0;

  function automatic int fir_lt(input int taps);
    return $clog2(taps);
  endfunction

  function automatic int fir_cw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int fir_sw(input int w, input int taps);
    return w + $clog2(taps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_line.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_line
// Brief    : Per-channel circular sample storage, one read and one write per
//            cycle, with lazy whole-channel clear through entry valid bits.
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_line
  import fir_mc_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int TAPS = 4,
  parameter  int CH   = 2,
  localparam int LT   = fir_lt(TAPS),
  localparam int CW   = fir_cw(CH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] rd_ch,
  input  logic [LT-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [LT-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          clr,
  input  logic [CW-1:0] clr_ch
);

  logic [W-1:0]    r_mem [CH][TAPS];
  logic [TAPS-1:0] r_vld [CH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_ch][wr_idx] <= wr_data;
    end
  end

  // A write in the same cycle as a clear of its channel survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        r_vld[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (clr && (clr_ch == CW'(c))) begin
          r_vld[c] <= '0;
        end
        if (wr_en && (wr_ch == CW'(c))) begin
          r_vld[c][wr_idx] <= 1'b1;
        end
      end
    end
  end

  assign rd_data = r_vld[rd_ch][rd_idx] ? r_mem[rd_ch][rd_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/fir_mc_avg.sv
`default_nettype none
// ============================================================================
// Module   : fir_mc_avg
// Brief    : Multi-channel TAPS-deep running-sum FIR, latency 2, one sample
//            per cycle. Define FIR_AVG_EN to add the rounded average output avg.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mc_avg
  import fir_mc_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int TAPS = 4,
  parameter  int CH   = 2,
  localparam int LT   = fir_lt(TAPS),
  localparam int CW   = fir_cw(CH),
  localparam int SW   = fir_sw(W, TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [W-1:0]  a,
  input  logic                 flush,
  input  logic [CW-1:0]        flush_ch,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [SW-1:0] s,
  output logic                 primed
`ifdef FIR_AVG_EN
  ,
  output logic signed [W-1:0]  avg
`endif
);

  typedef struct packed {
    logic [LT-1:0] wp;
    logic [LT:0]   fill;
    logic [SW-1:0] sum;
  } ch_state_t;

  localparam ch_state_t     C_ST_RST = '{wp:   LT'(C_WP_RST),
                                         fill: (LT+1)'(C_FILL_RST),
                                         sum:  SW'(C_SUM_RST)};
  localparam logic [LT:0]   C_FULL   = (LT+1)'(TAPS);
  localparam logic [CW:0]   C_CH_LIM = (CW+1)'(CH);
`ifdef FIR_AVG_EN
  localparam logic signed [SW-1:0] C_HALF = SW'(TAPS / 2);
`endif

  logic                 r_v;
  logic [CW-1:0]        r_ch;
  logic signed [W-1:0]  r_a;
  ch_state_t            r_st [CH];

  logic                 w_in_ok;
  logic                 w_fl_ok;
  logic                 w_fl_hit;
  ch_state_t            w_cur;
  ch_state_t            w_nxt;
  logic [W-1:0]         w_rd;
  logic signed [W-1:0]  w_old;
  logic signed [SW-1:0] w_sum_new;

  assign w_in_ok  = ({1'b0, in_ch} < C_CH_LIM);
  assign w_fl_ok  = flush && ({1'b0, flush_ch} < C_CH_LIM);
  assign w_fl_hit = w_fl_ok && (flush_ch == r_ch);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v  <= 1'b0;
      r_ch <= '0;
      r_a  <= '0;
    end else begin
      r_v  <= in_valid && w_in_ok;
      r_ch <= in_ch;
      r_a  <= a;
    end
  end

  // A flush landing on the stage-2 channel is applied before the sample.
  always_comb begin
    w_cur = r_st[r_ch];
    w_old = $signed(w_rd);
    if (w_fl_hit) begin
      w_cur = C_ST_RST;
      w_old = '0;
    end
    w_sum_new  = $signed(w_cur.sum) + SW'(r_a) - SW'(w_old);
    w_nxt.wp   = w_cur.wp + LT'(1);
    w_nxt.fill = (w_cur.fill == C_FULL) ? C_FULL : w_cur.fill + (LT+1)'(1);
    w_nxt.sum  = w_sum_new;
  end

  fir_tap_line #(
    .W    (W),
    .TAPS (TAPS),
    .CH   (CH)
  ) u_tap_line (
    .clk     (clk),
    .reset   (reset),
    .rd_ch   (r_ch),
    .rd_idx  (w_cur.wp),
    .rd_data (w_rd),
    .wr_en   (r_v),
    .wr_ch   (r_ch),
    .wr_idx  (w_cur.wp),
    .wr_data (r_a),
    .clr     (w_fl_ok),
    .clr_ch  (flush_ch)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        r_st[c] <= C_ST_RST;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (r_v && (r_ch == CW'(c))) begin
          r_st[c] <= w_nxt;
        end else if (w_fl_ok && (flush_ch == CW'(c))) begin
          r_st[c] <= C_ST_RST;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      s         <= '0;
      primed    <= 1'b0;
`ifdef FIR_AVG_EN
      avg       <= '0;
`endif
    end else begin
      out_valid <= r_v;
      if (r_v) begin
        out_ch <= r_ch;
        s      <= w_sum_new;
        primed <= (w_nxt.fill == C_FULL);
`ifdef FIR_AVG_EN
        avg    <= W'((w_sum_new + C_HALF) >>> LT);
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_avg.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mc_avg
// Brief    : Scoreboard bench for fir_mc_avg (W=16, TAPS=4, CH=2) with a
//            sliding-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mc_avg;

  localparam int W    = 16;
  localparam int TAPS = 4;
  localparam int CH   = 2;
  localparam int CW   = 1;
  localparam int SW   = 18;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [CW-1:0]        in_ch;
  logic signed [W-1:0]  a;
  logic                 flush;
  logic [CW-1:0]        flush_ch;
  logic                 out_valid;
  logic [CW-1:0]        out_ch;
  logic signed [SW-1:0] s;
  logic                 primed;
`ifdef FIR_AVG_EN
  logic signed [W-1:0]  avg;
`endif

  always #5 clk = ~clk;

  fir_mc_avg #(.W(W), .TAPS(TAPS), .CH(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .a         (a),
    .flush     (flush),
    .flush_ch  (flush_ch),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .s         (s),
    .primed    (primed)
`ifdef FIR_AVG_EN
    ,
    .avg       (avg)
`endif
  );

  typedef struct {
    int ch;
    int s;
    int primed;
    int avg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference: the window of each channel's most recent samples, newest first.
  int   win [CH][TAPS];
  int   cnt [CH];
  bit   pend_v;
  int   pend_ch;
  int   pend_a;
  int   last_s;

  function automatic void check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic void model_flush(int ch);
    for (int i = 0; i < TAPS; i++) win[ch][i] = 0;
    cnt[ch] = 0;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) model_flush(c);
    pend_v = 0;
    sb.delete();
  endfunction

  function automatic void model_sample(int ch, int smp);
    exp_t e;
    int   sum;
    for (int i = TAPS - 1; i > 0; i--) win[ch][i] = win[ch][i-1];
    win[ch][0] = smp;
    if (cnt[ch] < TAPS) cnt[ch]++;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += win[ch][i];
    e.ch     = ch;
    e.s      = sum;
    e.primed = (cnt[ch] == TAPS) ? 1 : 0;
    e.avg    = (sum + TAPS / 2) >>> $clog2(TAPS);
    sb.push_back(e);
  endfunction

  // One clock of stimulus; the model sees the flush before the stage-2 sample.
  task automatic step(input bit v, input int ch, input int smp,
                      input bit fl, input int flch);
    in_valid = v;
    in_ch    = CW'(ch);
    a        = W'(smp);
    flush    = fl;
    flush_ch = CW'(flch);
    @(posedge clk);
    if (fl && flch < CH) model_flush(flch);
    if (pend_v) model_sample(pend_ch, pend_a);
    pend_v  = v && (ch < CH);
    pend_ch = ch;
    pend_a  = smp;
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_s", int'(s), 0);
    check("rst_primed", int'(primed), 0);
`ifdef FIR_AVG_EN
    check("rst_avg", int'(avg), 0);
`endif
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      last_s = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: out_valid=1 with nothing expected, s=%0d", s);
      end else begin
        mon_e = sb.pop_front();
        check("out_ch", int'(out_ch), mon_e.ch);
        check("s", int'(s), mon_e.s);
        check("primed", int'(primed), mon_e.primed);
`ifdef FIR_AVG_EN
        check("avg", int'(avg), mon_e.avg);
`endif
        last_s = mon_e.s;
      end
    end else begin
      check("hold_s", int'(s), last_s);
    end
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_ch    = '0;
    a        = '0;
    flush    = 1'b0;
    flush_ch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;

    // Warm-up on channel 0
    for (int i = 1; i <= 6; i++) step(1, 0, i, 0, 0);
    idle(3);

    // Interleaved channels from a clean start
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, i % 2, (i % 2) ? -100 : 100, 0, 0);
    idle(3);

    // Full-scale positive then negative window
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 32767, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, -32768, 0, 0);
    idle(3);

    // Flush colliding with a same-channel sample, in stage 2 and in stage 1
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 5, 0, 0);
      step(1, 0, 20 + i, 0, 0);
    end
    step(1, 1, 7, 0, 0);
    step(1, 0, 9, 1, 1);
    step(1, 1, 8, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 5, 0, 0);
    step(1, 1, 7, 1, 1);
    step(1, 0, 11, 0, 0);
    step(0, 0, 0, 1, 1);
    idle(3);

    // Rounded average behaviour on fresh channels
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, i, 0, 0);
    step(0, 0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) step(1, 1, -i, 0, 0);
    idle(3);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1));
    end

    // Reset in the middle of a stream
    step(1, 0, 123, 0, 0);
    step(1, 1, -5, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 0, -3, 0, 0);
    idle(4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
